rv32_trace_uart_tx: RTL and testbench
=====================================

// Module: rv32_trace_uart_tx
// PURPOSE
//  On-chip producer of the retirement trace and end-of-run report that the
//  system bench prints. Sits beside rv32_system_top. Captures {pc, wb_result}
//  per retired instruction into a FIFO and serialises the records on a UART TX
//  line. Also emits one final frame: HALT, or TIMEOUT if the cycle budget runs out.
// PARAMETERS
//  CLKS_PER_BIT    16   clk cycles per UART bit (>=2)
//  FIFO_DEPTH      8    trace records buffered (power of 2, >=2)
//  TIMEOUT_CYCLES  350  post-reset cycle budget before the TIMEOUT frame
// PORTS
//  clk          in   1   system clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  trace_valid  in   1   one instruction retired this cycle
//  trace_pc     in   32  PC of the retired instruction
//  trace_wb     in   32  write-back result
//  halt         in   1   processor halt, level
//  tx           out  1   UART serial out, idle high
//  tx_busy      out  1   byte serialiser active
//  overflow     out  1   sticky: a record was dropped
//  done         out  1   final frame fully sent; block inert until reset
// BEHAVIOUR
//  Reset values:
//  - tx=1, tx_busy=0, overflow=0, done=0.
//  - FIFO empty; cycle_cnt=0; FSM=IDLE.
//  Cycle counter:
//  - 32 bit; counts every clk after reset and saturates at all-ones.
//  - timeout_hit latches when cycle_cnt==TIMEOUT_CYCLES and halt not yet latched.
//  - halt_seen latches on the first sampled halt=1.
//  - halt and timeout in the same cycle: halt wins, timeout_hit is never set.
//  FIFO push:
//  - On trace_valid=1, until halt_seen/timeout_hit is latched.
//  - Accepted if FIFO not full, or a pop occurs in the same cycle.
//  - Otherwise the record is dropped and overflow is set.
//  Frame formats (bytes, in order):
//  - TRACE: 0xA5, pc[7:0] .. pc[31:24], wb[7:0] .. wb[31:24] (9 bytes).
//  - HALT: 0x5A, cycle_cnt at latch, LSB first (5 bytes).
//  - TIMEOUT: 0xEE, cycle_cnt at latch, LSB first (5 bytes).
//  FSM states:
//  - IDLE: FIFO non-empty -> pop into a 72-bit shift buffer, SEND_TRACE.
//    Else if halt_seen or timeout_hit -> load the final frame, SEND_FINAL.
//    FIFO entries always drain before the final frame is sent.
//  - SEND_TRACE: issue the 9 bytes in order, then IDLE.
//  - SEND_FINAL: issue the 5 bytes in order, then DONE.
//  - DONE: done=1, tx=1; all inputs ignored.
//  UART byte timing:
//  - 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
//  - Each bit lasts exactly CLKS_PER_BIT clk; one byte is 10*CLKS_PER_BIT clk.
//  - The next byte's start bit begins on the clk after the stop bit ends, with no idle gap.
//  Latency:
//  - Push at edge E into an empty FIFO with FSM in IDLE.
//  - tx goes low (header start bit) after edge E+2.
//  Reset mid-frame: tx returns high immediately; the partial byte is abandoned.
// STRUCTURE
//  Package rv32_trace_pkg:
//  - HDR_TRACE=8'hA5, HDR_HALT=8'h5A, HDR_TIMEOUT=8'hEE.
//  - typedef trace_rec_t {logic [31:0] pc; logic [31:0] wb;}.
//  - enum trace_state_t {IDLE, SEND_TRACE, SEND_FINAL, DONE}.
//  Sub-module uart_tx_byte (CLKS_PER_BIT):
//  - Inputs start and data[7:0]; outputs tx, busy, and a 1-cycle byte_done.
//  - start is accepted only when not busy.
//  Top level holds the FIFO (registers, ptr+1 wrap bits), counter, FSM and byte sequencer.
// TESTING
//  All directed tests use CLKS_PER_BIT=4, FIFO_DEPTH=4, TIMEOUT_CYCLES=350.
//  1 Single record pc=0x0000_0004, wb=0x0000_002A:
//    tx bytes A5 04 00 00 00 2A 00 00 00; each bit 4 clk; start bit low 2 edges after push.
//  2 Back-to-back: 5 consecutive pushes while the first frame is in flight.
//    4 frames sent, 1 dropped, overflow=1 and stays 1.
//  3 Halt at cycle 37 with 2 records queued:
//    both TRACE frames first, then 5A 25 00 00 00, then done=1, tx=1.
//  4 No halt ever: at cycle_cnt=350 the block emits EE 5E 01 00 00 and sets done.
//    trace_valid afterwards produces no bytes.
//  5 Halt rises on the same edge cycle_cnt==350: HALT frame 5A 5E 01 00 00; no EE frame.
//  6 rst_n low in the middle of the 3rd data bit:
//    tx=1, tx_busy=0 immediately; after release the FIFO is empty and no bytes are sent.

Source files
------------

// File: rtl/rv32_trace_pkg.sv
// Shared types and frame header codes for the retirement trace UART producer.
package rv32_trace_pkg;

  localparam logic [7:0] HDR_TRACE   = 8'hA5;
  localparam logic [7:0] HDR_HALT    = 8'h5A;
  localparam logic [7:0] HDR_TIMEOUT = 8'hEE;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] wb;
  } trace_rec_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND_TRACE,
    SEND_FINAL,
    DONE
  } trace_state_t;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser. busy drops during the last clock of the stop bit so a
// follow-on start lands exactly when the stop bit ends (no idle gap).
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy,
  output logic       byte_done
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  logic          active;
  logic [CW-1:0] clk_cnt;
  logic [3:0]    bit_idx;   // 0 = start, 1..8 = data, 9 = stop
  logic [7:0]    sh;
  logic          tx_q;
  logic          last_clk;

  assign last_clk  = (clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign byte_done = active && last_clk && (bit_idx == 4'd9);
  assign busy      = active && !byte_done;
  assign tx        = tx_q;

  // Bit timer and shift register; start has priority so bytes chain back-to-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active  <= 1'b0;
      clk_cnt <= '0;
      bit_idx <= '0;
      sh      <= '0;
      tx_q    <= 1'b1;
    end else if (start && !busy) begin
      active  <= 1'b1;
      clk_cnt <= '0;
      bit_idx <= '0;
      sh      <= data;
      tx_q    <= 1'b0;
    end else if (active) begin
      if (last_clk) begin
        clk_cnt <= '0;
        if (bit_idx == 4'd9) begin
          active <= 1'b0;
          tx_q   <= 1'b1;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          if (bit_idx == 4'd8) begin
            tx_q <= 1'b1;
          end else begin
            tx_q <= sh[0];
            sh   <= sh >> 1;
          end
        end
      end else begin
        clk_cnt <= clk_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/rv32_trace_uart_tx.sv
// Retirement trace capture FIFO, cycle budget, and frame sequencer feeding a
// UART byte serialiser. Ends with one HALT or TIMEOUT frame, then goes inert.
module rv32_trace_uart_tx
  import rv32_trace_pkg::*;
#(
  parameter int CLKS_PER_BIT   = 16,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 350
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trace_valid,
  input  logic [31:0] trace_pc,
  input  logic [31:0] trace_wb,
  input  logic        halt,
  output logic        tx,
  output logic        tx_busy,
  output logic        overflow,
  output logic        done
);

  localparam int AW = $clog2(FIFO_DEPTH);

  trace_state_t state, state_n;

  logic [31:0] cycle_cnt, cnt_lat;
  logic        halt_seen, timeout_hit;

  trace_rec_t  mem [FIFO_DEPTH];
  trace_rec_t  rd_rec;
  logic [AW:0] wptr, rptr;
  logic        empty, full, pop, push_req, push_ok;

  logic [71:0] sbuf;
  logic [3:0]  byte_left;
  logic        u_start, u_busy, u_done, u_tx;

  // FIFO status: extra pointer bit distinguishes full from empty.
  assign empty    = (wptr == rptr);
  assign full     = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rd_rec   = mem[rptr[AW-1:0]];
  assign push_req = trace_valid && !halt_seen && !timeout_hit;
  assign push_ok  = push_req && (!full || pop);

  // Saturating post-reset cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cycle_cnt <= '0;
    else if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 32'd1;
  end

  // End-of-run latch; halt beats a same-cycle timeout, and only one ever sets.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_seen   <= 1'b0;
      timeout_hit <= 1'b0;
      cnt_lat     <= '0;
    end else if (!halt_seen && !timeout_hit) begin
      if (halt) begin
        halt_seen <= 1'b1;
        cnt_lat   <= cycle_cnt;
      end else if (cycle_cnt == 32'(TIMEOUT_CYCLES)) begin
        timeout_hit <= 1'b1;
        cnt_lat     <= cycle_cnt;
      end
    end
  end

  // FIFO storage; no reset needed since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= '{pc: trace_pc, wb: trace_wb};
  end

  // FIFO pointers and sticky drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + (AW+1)'(1);
      if (pop)     rptr <= rptr + (AW+1)'(1);
      if (push_req && !push_ok) overflow <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next state, FIFO pop and byte issue; trace records always drain first.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    u_start = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_n = SEND_TRACE;
        end else if (halt_seen || timeout_hit) begin
          state_n = SEND_FINAL;
        end
      end
      SEND_TRACE, SEND_FINAL: begin
        u_start = (byte_left != 4'd0) && !u_busy;
        if (byte_left == 4'd0 && u_done)
          state_n = (state == SEND_TRACE) ? IDLE : DONE;
      end
      default: ;
    endcase
  end

  // Frame shift buffer: loaded in IDLE, shifted one byte per accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sbuf      <= '0;
      byte_left <= '0;
    end else if (state == IDLE) begin
      if (!empty) begin
        sbuf      <= {rd_rec.wb, rd_rec.pc, HDR_TRACE};
        byte_left <= 4'd9;
      end else if (halt_seen || timeout_hit) begin
        sbuf      <= {32'b0, cnt_lat, (halt_seen ? HDR_HALT : HDR_TIMEOUT)};
        byte_left <= 4'd5;
      end
    end else if (u_start) begin
      sbuf      <= sbuf >> 8;
      byte_left <= byte_left - 4'd1;
    end
  end

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (u_start),
    .data      (sbuf[7:0]),
    .tx        (u_tx),
    .busy      (u_busy),
    .byte_done (u_done)
  );

  assign tx      = u_tx;
  assign tx_busy = u_busy | u_done;
  assign done    = (state == DONE);

endmodule

// File: tb/tb_rv32_trace_uart_tx.sv
// Bench for rv32_trace_uart_tx: a UART receiver decodes tx into bytes, which are
// compared against frames built from the pushed records and end-of-run rules.
module tb_rv32_trace_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int TMO   = 350;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        trace_valid = 1'b0;
  logic [31:0] trace_pc = '0;
  logic [31:0] trace_wb = '0;
  logic        halt = 1'b0;
  logic        tx, tx_busy, overflow, done;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] cyc;
  logic [7:0]  rx_q[$];
  logic [7:0]  exp_q[$];
  int          st_q[$];

  rv32_trace_uart_tx #(
    .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .trace_valid(trace_valid), .trace_pc(trace_pc),
    .trace_wb(trace_wb), .halt(halt), .tx(tx), .tx_busy(tx_busy),
    .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  // Clock edges seen since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= '0;
    else        cyc <= cyc + 32'd1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // UART receiver: samples mid-bit; bytes cut by reset are discarded.
  initial begin : mon
    logic [7:0] b;
    logic       bad;
    int         t0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        t0  = int'(cyc);
        bad = 1'b0;
        repeat (CPB/2) @(negedge clk);
        if (rst_n !== 1'b1 || tx !== 1'b0) bad = 1'b1;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = tx;
          if (rst_n !== 1'b1) bad = 1'b1;
        end
        repeat (CPB) @(negedge clk);
        if (rst_n !== 1'b1) bad = 1'b1;
        if (!bad) begin
          chk("stop_bit", tx, 1);
          rx_q.push_back(b);
          st_q.push_back(t0);
        end
      end
    end
  end

  task automatic add_trace(input logic [31:0] pc, input logic [31:0] wb);
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 4; i++) exp_q.push_back(pc[8*i +: 8]);
    for (int i = 0; i < 4; i++) exp_q.push_back(wb[8*i +: 8]);
  endtask

  task automatic add_final(input logic [7:0] hdr, input logic [31:0] cnt);
    exp_q.push_back(hdr);
    for (int i = 0; i < 4; i++) exp_q.push_back(cnt[8*i +: 8]);
  endtask

  task automatic cmp_stream(input string tag);
    chk({tag, "_len"}, rx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk(tag, rx_q[i], exp_q[i]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; trace_valid = 1'b0; halt = 1'b0;
    repeat (3) @(negedge clk);
    rx_q.delete(); exp_q.delete(); st_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input string tag, input int max);
    int n = 0;
    while (done !== 1'b1 && n < max) begin @(negedge clk); n++; end
    chk(tag, done, 1);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_busy(input string tag);
    int n = 0;
    while (tx_busy !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk(tag, tx_busy, 1);
  endtask

  task automatic wait_cyc(input string tag, input int target);
    int n = 0;
    while (cyc != 32'(target) && n < 1000) begin @(negedge clk); n++; end
    chk(tag, cyc, target);
  endtask

  initial begin
    logic [31:0] pc, wb;
    // Reset values
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_done", done, 0);

    // 1: single record, latency, byte spacing; budget expires mid-frame
    do_reset();
    @(negedge clk);
    trace_pc = 32'h0000_0004; trace_wb = 32'h0000_002A; trace_valid = 1'b1;
    add_trace(32'h0000_0004, 32'h0000_002A);
    @(negedge clk);
    trace_valid = 1'b0;
    @(negedge clk);
    chk("t1_lat_e1", tx, 1);
    @(negedge clk);
    chk("t1_lat_e2", tx, 0);
    chk("t1_busy", tx_busy, 1);
    add_final(8'hEE, 32'(TMO));
    wait_done("t1_done", 3000);
    cmp_stream("t1_bytes");
    chk("t1_nstarts", st_q.size(), 14);
    for (int k = 0; k < 8 && k + 1 < st_q.size(); k++)
      chk("t1_gap", st_q[k+1] - st_q[k], 10*CPB);

    // 2: burst of 5 pushes while first frame is in flight
    do_reset();
    @(negedge clk);
    pc = $urandom; wb = $urandom;
    trace_pc = pc; trace_wb = wb; trace_valid = 1'b1; add_trace(pc, wb);
    @(negedge clk);
    trace_valid = 1'b0;
    wait_busy("t2_busy");
    for (int i = 0; i < 5; i++) begin
      pc = $urandom; wb = $urandom;
      trace_pc = pc; trace_wb = wb; trace_valid = 1'b1;
      if (i < DEPTH) add_trace(pc, wb);
      @(negedge clk);
      chk("t2_ovf_step", overflow, (i == DEPTH) ? 1 : 0);
    end
    trace_valid = 1'b0;
    add_final(8'hEE, 32'(TMO));
    wait_done("t2_done", 4000);
    cmp_stream("t2_bytes");
    chk("t2_ovf_sticky", overflow, 1);

    // 3: two records queued, halt at cycle 37
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      pc = $urandom; wb = $urandom;
      trace_pc = pc; trace_wb = wb; trace_valid = 1'b1; add_trace(pc, wb);
      @(negedge clk);
    end
    trace_valid = 1'b0;
    wait_cyc("t3_cyc", 37);
    halt = 1'b1;
    add_final(8'h5A, 32'd37);
    wait_done("t3_done", 3000);
    cmp_stream("t3_bytes");
    chk("t3_tx_idle", tx, 1);

    // 4: no halt, timeout frame; later trace_valid ignored
    do_reset();
    add_final(8'hEE, 32'(TMO));
    wait_done("t4_done", 1500);
    cmp_stream("t4_bytes");
    for (int i = 0; i < 3; i++) begin
      trace_pc = $urandom; trace_wb = $urandom; trace_valid = 1'b1;
      @(negedge clk);
    end
    trace_valid = 1'b0;
    repeat (100) @(negedge clk);
    chk("t4_no_more", rx_q.size(), 5);
    chk("t4_tx", tx, 1);
    chk("t4_done_hold", done, 1);

    // 5: halt on the same edge as the budget limit
    do_reset();
    wait_cyc("t5_cyc", TMO);
    halt = 1'b1;
    add_final(8'h5A, 32'(TMO));
    wait_done("t5_done", 1500);
    cmp_stream("t5_bytes");

    // 6: reset in the middle of the third data bit
    do_reset();
    @(negedge clk);
    trace_pc = $urandom; trace_wb = $urandom; trace_valid = 1'b1;
    @(negedge clk);
    trace_valid = 1'b0;
    wait_busy("t6_busy");
    repeat (3*CPB + 1) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_tx_now", tx, 1);
    chk("t6_busy_now", tx_busy, 0);
    chk("t6_done_now", done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    chk("t6_no_bytes", rx_q.size(), 0);
    chk("t6_tx_idle", tx, 1);
    chk("t6_busy_idle", tx_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
